// File: rtl/seg_scan_controller.sv
// Four-digit 7-segment scan sequencer with frame-aligned double buffering,
// per-slot blanking against ghosting, and optional leading-zero suppression.
module seg_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic [3:0]  digit_4,
  output logic [1:0]  refresh_count,
  output logic [3:0]  anode,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   refresh_count_q, refresh_count_d;
  logic [15:0]  pending_val_q, pending_val_d;
  logic [3:0]   pending_dp_q, pending_dp_d;
  logic [15:0]  active_val_q, active_val_d;
  logic [3:0]   active_dp_q, active_dp_d;
  logic [3:0]   anode_q, anode_d;
  logic         dp_q, dp_d;
  logic         frame_done_q, frame_done_d;

  logic         slot_wrap;
  logic         frame_wrap;
  logic         upper_zero;
  logic [3:0]   suppress;

  always_comb begin
    slot_wrap       = (cnt_q == CNT_LAST);
    frame_wrap      = slot_wrap && (refresh_count_q == 2'd3);
    cnt_d           = slot_wrap ? '0 : cnt_q + CW'(1);
    refresh_count_d = slot_wrap ? refresh_count_q + 2'd1 : refresh_count_q;

    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (slot_wrap)           state_d = ST_BLANK;
      default:                           state_d = ST_BLANK;
    endcase

    pending_val_d = load ? value_in : pending_val_q;
    pending_dp_d  = load ? dp_in    : pending_dp_q;
    // Active is taken from pending_d so a load on the wrap edge bypasses straight in.
    active_val_d  = frame_wrap ? pending_val_d : active_val_q;
    active_dp_d   = frame_wrap ? pending_dp_d  : active_dp_q;

    upper_zero = 1'b1;
    suppress   = '0;
    for (int k = 3; k >= 0; k--) begin
      upper_zero  = upper_zero && (active_val_d[4*k +: 4] == 4'd0);
      suppress[k] = blank_lz && upper_zero && !active_dp_d[k] && (k != 0);
    end

    // Outputs are computed for the next cycle's slot so they line up with cnt/refresh_count.
    anode_d = 4'b1111;
    dp_d    = 1'b1;
    if (state_d == ST_SHOW && !suppress[refresh_count_d]) begin
      anode_d[refresh_count_d] = 1'b0;
      dp_d                     = ~active_dp_d[refresh_count_d];
    end

    frame_done_d = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_BLANK;
      cnt_q           <= '0;
      refresh_count_q <= 2'd0;
      pending_val_q   <= '0;
      pending_dp_q    <= '0;
      active_val_q    <= '0;
      active_dp_q     <= '0;
      anode_q         <= 4'b1111;
      dp_q            <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      refresh_count_q <= refresh_count_d;
      pending_val_q   <= pending_val_d;
      pending_dp_q    <= pending_dp_d;
      active_val_q    <= active_val_d;
      active_dp_q     <= active_dp_d;
      anode_q         <= anode_d;
      dp_q            <= dp_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign digit_1       = active_val_q[3:0];
  assign digit_2       = active_val_q[7:4];
  assign digit_3       = active_val_q[11:8];
  assign digit_4       = active_val_q[15:12];
  assign refresh_count = refresh_count_q;
  assign anode         = anode_q;
  assign dp            = dp_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed scenarios plus random traffic against a cycle-count reference model
// of the scan controller (SCAN_DIV=8, BLANK_CYCLES=2).
module tb_seg_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset, load, blank_lz;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;
  logic [1:0]  refresh_count;
  logic [3:0]  anode;
  logic        dp, frame_done;

  seg_scan_controller #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .digit_4(digit_4), .refresh_count(refresh_count), .anode(anode), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: cycles since reset plus the two display buffers.
  int          m_t = 0;
  logic [15:0] m_pv = '0, m_av = '0;
  logic [3:0]  m_pd = '0, m_ad = '0;
  logic [3:0]  e_an;
  logic        e_dp, e_fd;
  logic [1:0]  e_rc;

  function automatic bit suppressed(int slot, logic lz);
    if (!lz || slot == 0) return 1'b0;
    if ((m_av >> (4 * slot)) != 16'd0) return 1'b0;
    return !m_ad[slot];
  endfunction

  task automatic model_edge();
    int slot, pos;
    bit lit;
    if (reset) begin
      m_t = 0; m_pv = '0; m_pd = '0; m_av = '0; m_ad = '0;
    end else begin
      if (load) begin m_pv = value_in; m_pd = dp_in; end
      m_t++;
      if (m_t % FRAME == 0) begin m_av = m_pv; m_ad = m_pd; end
    end
    slot = (m_t / SD) % 4;
    pos  = m_t % SD;
    e_rc = 2'(slot);
    e_fd = (m_t > 0) && (m_t % FRAME == 0);
    lit  = (pos >= BC) && !suppressed(slot, blank_lz);
    e_an = lit ? ~(4'b0001 << slot) : 4'b1111;
    e_dp = lit ? ~m_ad[slot] : 1'b1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("anode", {12'd0, anode}, {12'd0, e_an});
    chk("dp", {15'd0, dp}, {15'd0, e_dp});
    chk("refresh_count", {14'd0, refresh_count}, {14'd0, e_rc});
    chk("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
    chk("digits", {digit_4, digit_3, digit_2, digit_1}, m_av);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] vtmp;
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; value_in = '0; dp_in = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset release: blank/show timing and slot order
    repeat (40) tick();

    // Mid-frame load only lands at the frame wrap
    while (m_t % FRAME != 12) tick();
    do_load(16'h1234, 4'b0000);
    repeat (70) tick();

    // Leading-zero suppression on and off
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    repeat (70) tick();
    blank_lz = 1'b0;
    repeat (40) tick();

    // Decimal point protects a zero digit from suppression
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0100);
    repeat (70) tick();

    // Value 0000 still shows the right digit
    do_load(16'h0000, 4'b0000);
    repeat (70) tick();
    blank_lz = 1'b0;

    // Load on the exact wrap edge bypasses into active
    while (m_t % FRAME != 10) tick();
    do_load(16'h1111, 4'b0000);
    while ((m_t + 1) % FRAME != 0) tick();
    do_load(16'h2222, 4'b0001);
    repeat (40) tick();

    // Reset during SHOW of slot 2 discards the pending load
    while (m_t % FRAME != 2 * SD + 4) tick();
    do_load(16'h9876, 4'b1010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (70) tick();

    // Random traffic, including non-BCD digits and leading zeros
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom % 8 == 0);
      vtmp = 16'($urandom);
      value_in = vtmp >> (4 * $urandom_range(0, 4));
      dp_in = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom % 16 == 0) blank_lz = ~blank_lz;
      reset = ($urandom % 300 == 0);
      tick();
    end
    load = 1'b0; reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
